parking_meter_display: RTL and testbench

- Consumer end of the parking-meter button/switch interface.
- Takes single-cycle add pulses and level reset switches, keeps the remaining time in seconds (0..9999), and decrements it once per second.
- Drives the 4-digit multiplexed seven-segment display, including the low-time and expired flash patterns.
- Sits between the input conditioning block and the board display pins.

---
 rtl/parking_meter_display.sv | 155 +++++++++++++++
 tb/tb_parking_meter_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parking_meter_display.sv
// rtl/parking_meter_display.sv - parking meter time keeper and 4-digit seven-segment display driver
//
// Purpose: keeps remaining parking time in seconds (0..MAX_TIME), applies add
// pulses and level-held preset switches, decrements once per second, and
// drives a multiplexed 4-digit active-low seven-segment display with
// low-time (1 s on / 1 s off) and expired (half-second) flash patterns.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   add_10/180/200/550  single-cycle pulses adding that many seconds
//   rst_to_10   level: force time to 10 s
//   rst_to_205  level: force time to 205 s (wins over rst_to_10)
//   time_left   registered remaining seconds
//   expired     high when time_left == 0
//   an          digit anodes, active-low, an[0] = ones digit (registered)
//   seg         cathodes {g,f,e,d,c,b,a}, active-low (registered)
//   dp          decimal point, always off
module parking_meter_display #(
    parameter int CLOCKS_PER_SEC = 100000000,
    parameter int SCAN_DIV       = 100000,
    parameter int MAX_TIME       = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        add_10,
    input  logic        add_180,
    input  logic        add_200,
    input  logic        add_550,
    input  logic        rst_to_10,
    input  logic        rst_to_205,
    output logic [13:0] time_left,
    output logic        expired,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SW = $clog2(CLOCKS_PER_SEC);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SEC_LAST  = SW'(CLOCKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_HALF  = SW'(CLOCKS_PER_SEC / 2 - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [14:0]   MAX15     = 15'(MAX_TIME);

    logic [SW-1:0] sec_cnt_q, sec_cnt_d;
    logic          half_q, half_d;
    logic [13:0]   time_q, time_d;
    logic [CW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          sw_active;
    logic          disp_on;
    logic [14:0]   adds;
    logic [14:0]   sum;
    logic [3:0]    dig_th, dig_hu, dig_te, dig_on, dig_sel;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick      = (sec_cnt_q == SEC_LAST);
        sw_active = rst_to_205 | rst_to_10;

        // A preset switch holds the second counter at zero so the first
        // decrement after release lands a full second later.
        if (sw_active) begin
            sec_cnt_d = '0;
            half_d    = 1'b0;
        end else begin
            sec_cnt_d = tick ? '0 : sec_cnt_q + 1'b1;
            half_d    = (tick || sec_cnt_q == SEC_HALF) ? ~half_q : half_q;
        end

        adds = (add_10  ? 15'd10  : 15'd0) + (add_180 ? 15'd180 : 15'd0)
             + (add_200 ? 15'd200 : 15'd0) + (add_550 ? 15'd550 : 15'd0);
        // dec only when time is non-zero, so the 15-bit sum never underflows.
        sum  = {1'b0, time_q} - {14'd0, (tick && time_q != 14'd0)} + adds;

        if (rst_to_205)     time_d = 14'd205;
        else if (rst_to_10) time_d = 14'd10;
        else if (sum > MAX15) time_d = MAX15[13:0];
        else                time_d = sum[13:0];

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + 1'b1;
            idx_d  = idx_q;
        end

        if (time_q >= 14'd180)      disp_on = 1'b1;
        else if (time_q != 14'd0)   disp_on = ~time_q[0];
        else                        disp_on = ~half_q;

        dig_th = 4'(time_q / 14'd1000);
        dig_hu = 4'((time_q / 14'd100) % 14'd10);
        dig_te = 4'((time_q / 14'd10) % 14'd10);
        dig_on = 4'(time_q % 14'd10);

        case (idx_q)
            2'd0:    dig_sel = dig_on;
            2'd1:    dig_sel = dig_te;
            2'd2:    dig_sel = dig_hu;
            default: dig_sel = dig_th;
        endcase

        an_d  = disp_on ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d = disp_on ? seg_of(dig_sel) : 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            half_q    <= 1'b0;
            time_q    <= 14'd0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            half_q    <= half_d;
            time_q    <= time_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign time_left = time_q;
    assign expired   = (time_q == 14'd0);
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_parking_meter_display.sv
// tb/tb_parking_meter_display.sv - self-checking bench for parking_meter_display
module tb_parking_meter_display;

    localparam int CPS  = 10;
    localparam int SCAN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        add_10 = 1'b0, add_180 = 1'b0, add_200 = 1'b0, add_550 = 1'b0;
    logic        rst_to_10 = 1'b0, rst_to_205 = 1'b0;
    logic [13:0] time_left;
    logic        expired;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    parking_meter_display #(
        .CLOCKS_PER_SEC(CPS),
        .SCAN_DIV      (SCAN),
        .MAX_TIME      (9999)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_10    (add_10),
        .add_180   (add_180),
        .add_200   (add_200),
        .add_550   (add_550),
        .rst_to_10 (rst_to_10),
        .rst_to_205(rst_to_205),
        .time_left (time_left),
        .expired   (expired),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: time in seconds, position within the current second,
    // scan position and the digit being shown, plus the expected display
    // outputs (registered, so derived from the state before each edge).
    int         m_time  = 0;
    int         m_phase = 0;
    int         m_scan  = 0;
    int         m_digit = 0;
    logic [3:0] m_an    = 4'b1111;
    logic [6:0] m_seg   = 7'b1111111;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int         pow10 [4] = '{1, 10, 100, 1000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit a10, a180, a200, a550, s10, s205, rn);
        bit on;
        int t;
        if (!rn) begin
            m_time = 0; m_phase = 0; m_scan = 0; m_digit = 0;
            m_an = 4'b1111; m_seg = 7'b1111111;
            return;
        end
        if (m_time >= 180)   on = 1'b1;
        else if (m_time > 0) on = (m_time % 2) == 0;
        else                 on = (m_phase < CPS / 2);
        if (on) begin
            m_an  = 4'b1111 & ~(4'b0001 << m_digit);
            m_seg = seg_tab[(m_time / pow10[m_digit]) % 10];
        end else begin
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
        end
        if (m_scan == SCAN - 1) begin
            m_scan  = 0;
            m_digit = (m_digit + 1) % 4;
        end else begin
            m_scan++;
        end
        if (s205) begin
            m_time = 205; m_phase = 0;
        end else if (s10) begin
            m_time = 10;  m_phase = 0;
        end else begin
            t = m_time + (a10 ? 10 : 0) + (a180 ? 180 : 0) + (a200 ? 200 : 0) + (a550 ? 550 : 0);
            if (m_phase == CPS - 1 && m_time > 0) t = t - 1;
            m_time  = (t > 9999) ? 9999 : t;
            m_phase = (m_phase + 1) % CPS;
        end
    endtask

    task automatic cyc(input bit a10, a180, a200, a550, s10, s205, rn);
        add_10 = a10; add_180 = a180; add_200 = a200; add_550 = a550;
        rst_to_10 = s10; rst_to_205 = s205; rst_n = rn;
        @(posedge clk);
        model_step(a10, a180, a200, a550, s10, s205, rn);
        #1;
        chk("time_left", 32'(time_left), 32'(m_time));
        chk("expired",   32'(expired),   32'(m_time == 0));
        chk("an",        32'(an),        32'(m_an));
        chk("seg",       32'(seg),       32'(m_seg));
        chk("dp",        32'(dp),        32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Idle until the next edge is a one-second tick edge.
    task automatic to_tick();
        while (m_phase != CPS - 1) idle(1);
    endtask

    initial begin
        // 1. reset and expired flash
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_time", 32'(time_left), 32'd0);
        chk("reset_an",   32'(an),        32'hF);
        idle(25);

        // 2. single add_550 then tick down
        cyc(0, 0, 0, 1, 0, 0, 1);
        chk("add550", 32'(time_left), 32'd550);
        idle(30);

        // 3. saturation and simultaneous adds
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("sat_200", 32'(time_left), 32'd9999);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("sat_10",  32'(time_left), 32'd9999);
        idle(12);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        chk("add_10_180", 32'(time_left), 32'd190);

        // 4. preset switch hold and release timing
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, (i % 3) == 0, 0, 1, 1);
        chk("hold205", 32'(time_left), 32'd205);
        idle(9);
        chk("rel_205_9", 32'(time_left), 32'd205);
        idle(1);
        chk("rel_205_10", 32'(time_left), 32'd204);
        cyc(0, 0, 0, 0, 1, 1, 1);
        chk("both_sw", 32'(time_left), 32'd205);

        // 5. count all the way down through the blink regions to expiry
        while (m_time != 0) idle(1);
        idle(30);

        // 6. tick coincident with add_10
        cyc(0, 0, 0, 0, 0, 0, 0);
        to_tick();
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("tick_add_at0", 32'(time_left), 32'd10);
        cyc(0, 0, 0, 0, 1, 0, 1);
        while (!(m_time == 5 && m_phase == CPS - 1)) idle(1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("tick_add_at5", 32'(time_left), 32'd14);

        // 7. randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit a10, a180, a200, a550, s10, s205, rn;
            a10  = ($urandom_range(0, 99) < 6);
            a180 = ($urandom_range(0, 99) < 3);
            a200 = ($urandom_range(0, 99) < 3);
            a550 = ($urandom_range(0, 99) < 2);
            s10  = ($urandom_range(0, 199) < 3);
            s205 = ($urandom_range(0, 199) < 3);
            rn   = ($urandom_range(0, 499) != 0);
            cyc(a10, a180, a200, a550, s10, s205, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
